// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors match referee:
// move codes, FSM state codes, match winner codes and the round result record.
package rps_pkg;

  // Player move encoding as presented by the switch front end
  localparam logic [1:0] MOVE_SCISSORS = 2'b00;
  localparam logic [1:0] MOVE_INVALID  = 2'b01;
  localparam logic [1:0] MOVE_PAPER    = 2'b10;
  localparam logic [1:0] MOVE_ROCK     = 2'b11;

  // Match FSM state encoding
  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_JUDGE = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  // match_winner codes, meaningful only while match_over is high
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // One decided round; at most one of a_win/b_win/tie is set
  typedef struct packed {
    logic a_win;
    logic b_win;
    logic tie;
    logic invalid;
  } round_result_t;

  // True when legal move x defeats legal move y
  function automatic logic move_beats(input logic [1:0] x, input logic [1:0] y);
    return ((x == MOVE_ROCK)     && (y == MOVE_SCISSORS)) ||
           ((x == MOVE_SCISSORS) && (y == MOVE_PAPER))    ||
           ((x == MOVE_PAPER)    && (y == MOVE_ROCK));
  endfunction

endpackage

// File: rtl/rps_round_judge.sv
// Combinational judge for one round, fed from the registered move pair.
// Optional macro RPS_FORFEIT_EN: an invalid move forfeits the round to the
// opponent (both invalid -> tie). Without it an invalid move yields no
// win/tie result at all and the referee rejects the round.
module rps_round_judge
  import rps_pkg::*;
(
  input  logic [1:0] move_a,
  input  logic [1:0] move_b,
  output logic       a_win,
  output logic       b_win,
  output logic       tie,
  output logic       invalid
);

  round_result_t res;
  logic          a_bad;
  logic          b_bad;

  assign a_bad = (move_a == MOVE_INVALID);
  assign b_bad = (move_b == MOVE_INVALID);

  // Decide the round outcome from the two moves
  always_comb begin
    res         = '0;
    res.invalid = a_bad | b_bad;
    if (res.invalid) begin
`ifdef RPS_FORFEIT_EN
      if (a_bad && b_bad) begin
        res.tie = 1'b1;
      end else if (a_bad) begin
        res.b_win = 1'b1;
      end else begin
        res.a_win = 1'b1;
      end
`endif
    end else if (move_a == move_b) begin
      res.tie = 1'b1;
    end else if (move_beats(move_a, move_b)) begin
      res.a_win = 1'b1;
    end else begin
      res.b_win = 1'b1;
    end
  end

  assign a_win   = res.a_win;
  assign b_win   = res.b_win;
  assign tie     = res.tie;
  assign invalid = res.invalid;

endmodule

// File: rtl/rps_match_referee.sv
// Match referee: accepts move pairs, judges each round, keeps scores and
// declares the match result. Round judging lives in rps_round_judge.
// Optional macro RPS_FORFEIT_EN (see rps_round_judge): invalid moves forfeit
// the round instead of rejecting it.
//
// state | meaning
// PLAY  | waiting for a move pair, round_ready high
// JUDGE | registered moves judged, result pulses out, counters update at exit
// OVER  | match decided, everything frozen until new_match or reset
module rps_match_referee #(
  parameter int WIN_SCORE  = 3,
  parameter int MAX_ROUNDS = 9,
  parameter int SCORE_W    = $clog2(MAX_ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_valid,
  input  logic [1:0]         player_a,
  input  logic [1:0]         player_b,
  input  logic               new_match,
  output logic               round_ready,
  output logic               round_done,
  output logic               player_a_wins,
  output logic               player_b_wins,
  output logic               tie_game,
  output logic               round_invalid,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [SCORE_W-1:0] round_count,
  output logic               match_over,
  output logic [1:0]         match_winner
);

  import rps_pkg::*;

  logic [1:0]         state;
  logic [1:0]         move_a_q;
  logic [1:0]         move_b_q;
  logic               j_a_win;
  logic               j_b_win;
  logic               j_tie;
  logic               j_invalid;
  logic               counted;
  logic               accept;
  logic               judge_live;
  logic [SCORE_W-1:0] score_a_nx;
  logic [SCORE_W-1:0] score_b_nx;
  logic [SCORE_W-1:0] round_count_nx;
  logic               go_over;
  logic [1:0]         winner_nx;

  rps_round_judge u_judge (
    .move_a  (move_a_q),
    .move_b  (move_b_q),
    .a_win   (j_a_win),
    .b_win   (j_b_win),
    .tie     (j_tie),
    .invalid (j_invalid)
  );

  // A move is dropped when new_match arrives in the same cycle
  assign accept  = (state == ST_PLAY) && move_valid && !new_match;
  assign counted = j_a_win | j_b_win | j_tie;

  // Post-update counter values used both for the registers and the end check
  always_comb begin
    score_a_nx     = score_a + SCORE_W'(j_a_win);
    score_b_nx     = score_b + SCORE_W'(j_b_win);
    round_count_nx = round_count + SCORE_W'(counted);
  end

  // Match end check on the post-update values
  always_comb begin
    go_over   = 1'b0;
    winner_nx = WIN_NONE;
    if (score_a_nx == SCORE_W'(WIN_SCORE)) begin
      go_over   = 1'b1;
      winner_nx = WIN_A;
    end else if (score_b_nx == SCORE_W'(WIN_SCORE)) begin
      go_over   = 1'b1;
      winner_nx = WIN_B;
    end else if (round_count_nx == SCORE_W'(MAX_ROUNDS)) begin
      go_over = 1'b1;
      if (score_a_nx > score_b_nx) begin
        winner_nx = WIN_A;
      end else if (score_b_nx > score_a_nx) begin
        winner_nx = WIN_B;
      end else begin
        winner_nx = WIN_DRAW;
      end
    end
  end

  // Capture the move pair on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_a_q <= MOVE_SCISSORS;
      move_b_q <= MOVE_SCISSORS;
    end else if (accept) begin
      move_a_q <= player_a;
      move_b_q <= player_b;
    end
  end

  // Match FSM with score and round counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_PLAY;
      score_a      <= '0;
      score_b      <= '0;
      round_count  <= '0;
      match_winner <= WIN_NONE;
    end else if (new_match) begin
      state        <= ST_PLAY;
      score_a      <= '0;
      score_b      <= '0;
      round_count  <= '0;
      match_winner <= WIN_NONE;
    end else begin
      case (state)
        ST_PLAY: begin
          if (accept) begin
            state <= ST_JUDGE;
          end
        end
        ST_JUDGE: begin
          // A rejected round leaves the counters alone and cannot end the match
          if (counted) begin
            score_a     <= score_a_nx;
            score_b     <= score_b_nx;
            round_count <= round_count_nx;
            if (go_over) begin
              state        <= ST_OVER;
              match_winner <= winner_nx;
            end else begin
              state <= ST_PLAY;
            end
          end else begin
            state <= ST_PLAY;
          end
        end
        ST_OVER: begin
          state <= ST_OVER;
        end
        default: begin
          state <= ST_PLAY;
        end
      endcase
    end
  end

  // Result pulses exist only in JUDGE, and new_match cancels them
  assign judge_live    = (state == ST_JUDGE) && !new_match;
  assign round_ready   = (state == ST_PLAY);
  assign round_done    = judge_live;
  assign player_a_wins = judge_live & j_a_win;
  assign player_b_wins = judge_live & j_b_win;
  assign tie_game      = judge_live & j_tie;
  assign round_invalid = judge_live & j_invalid;
  assign match_over    = (state == ST_OVER);

endmodule
